// File: rtl/bus_if_pw.sv
// bus_if_pw: memory-stage bus interface with zero-latency SPM routing, a posted write buffer
// and a request/grant bus master FSM. Define BUS_IF_TIMEOUT_EN to enable the access timeout.
module bus_if_pw #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 3,
  parameter int SPM_INDEX   = 1,
  parameter int WBUF_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              as_n,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              spm_as_n,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n,
  input  logic              bus_grnt_n,
  output logic              bus_req_n,
  output logic              bus_as_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  output logic              wbuf_empty,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2,
    S_STALL  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] r_wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_bus_req_n, r_bus_as_n, r_bus_rw, r_cur_rd;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wr_data, r_rd_buf;

  logic              w_req_valid, w_spm_hit, w_spm_go, w_rd_req, w_wr_req;
  logic              w_full, w_empty, w_enq, w_pop;
  logic              w_start, w_start_wr, w_grant, w_done, w_timeout;
  logic              w_rd_match, w_rd_ack;
  logic [DATA_W-1:0] w_rd_val;

  // Handshakes: the CPU holds {as_n, addr, rw, wr_data} while busy=1 and the access is taken
  // in the first cycle busy=0; on the bus, req_n stays low from REQ until rdy_n (or timeout).
  assign w_req_valid = !as_n && !flush;
  assign w_spm_hit   = (addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_INDEX));
  assign w_spm_go    = w_req_valid && w_spm_hit && !stall;
  assign w_rd_req    = w_req_valid && !w_spm_hit && rw;
  assign w_wr_req    = w_req_valid && !w_spm_hit && !rw;

  assign w_full  = (r_count == CNT_W'(WBUF_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = w_wr_req && !w_full;
  assign w_pop   = w_done && !r_cur_rd;

  assign spm_as_n    = !w_spm_go;
  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign w_grant  = (r_state == S_REQ) && !bus_grnt_n;
  assign w_done   = (r_state == S_ACCESS) && (!bus_rdy_n || w_timeout);
  assign w_rd_val = w_timeout ? '1 : bus_rd_data;

  // A completing read only answers the CPU if it is the same address still being requested.
  assign w_rd_match = (r_bus_addr == addr);
  assign w_rd_ack   = r_cur_rd && ((w_done && w_rd_match) || (r_state == S_STALL));

`ifdef BUS_IF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_grant) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && bus_rdy_n && (r_to_cnt != TO_W'(TIMEOUT_CYC))) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && bus_rdy_n && (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  assign err = w_timeout;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_wb_addr[r_wr_ptr] <= addr;
      r_wb_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
    end
  end

  assign wbuf_empty = w_empty;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Buffered writes always win in IDLE, so a read can never overtake an older write.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_start_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_start    = 1'b1;
          w_start_wr = 1'b1;
          w_next     = S_REQ;
        end else if (w_rd_req) begin
          w_start = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ:    if (!bus_grnt_n) w_next = S_ACCESS;
      S_ACCESS: if (w_done) w_next = (r_cur_rd && stall) ? S_STALL : S_IDLE;
      S_STALL:  if (!stall) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_req_n   <= 1'b1;
      r_bus_as_n    <= 1'b1;
      r_bus_addr    <= '0;
      r_bus_rw      <= 1'b1;
      r_bus_wr_data <= '0;
      r_cur_rd      <= 1'b0;
      r_rd_buf      <= '0;
    end else begin
      r_bus_as_n <= !w_grant;
      if (w_start) begin
        r_bus_req_n   <= 1'b0;
        r_bus_addr    <= w_start_wr ? r_wb_addr[r_rd_ptr] : addr;
        r_bus_rw      <= !w_start_wr;
        r_bus_wr_data <= w_start_wr ? r_wb_data[r_rd_ptr] : '0;
        r_cur_rd      <= !w_start_wr;
      end else if (w_done) begin
        r_bus_req_n   <= 1'b1;
        r_bus_addr    <= '0;
        r_bus_rw      <= 1'b1;
        r_bus_wr_data <= '0;
      end
      if (w_done && r_cur_rd) r_rd_buf <= w_rd_val;
    end
  end

  assign bus_req_n   = r_bus_req_n;
  assign bus_as_n    = r_bus_as_n;
  assign bus_addr    = r_bus_addr;
  assign bus_rw      = r_bus_rw;
  assign bus_wr_data = r_bus_wr_data;
  assign o_dbg_state = r_state;

  always_comb begin
    rd_data = '0;
    if (w_spm_go && rw) begin
      rd_data = spm_rd_data;
    end else if (w_rd_req && r_cur_rd && w_done && w_rd_match) begin
      rd_data = w_rd_val;
    end else if (w_rd_req && r_cur_rd && (r_state == S_STALL)) begin
      rd_data = r_rd_buf;
    end
  end

  assign busy = (w_rd_req && !w_rd_ack) || (w_wr_req && w_full);

endmodule
